// File: rtl/piso_pkg.sv
// Shared types and width helpers for the PISO transmit sequencer.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_DIV   = 2;

    function automatic int unsigned bit_cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic int unsigned div_cnt_w(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// Word handshake, frame control and serial output bundle for piso_tx_ctrl.
interface piso_tx_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, so, so_valid, busy, done
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, so, so_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_datapath.sv
// WIDTH-bit parallel-load shift register with zero fill and a single serial tap.
module piso_shift_datapath #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pl,
    input  logic             sh,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             tap
);
    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (pl) begin
            sr <= din;
        end else if (sh) begin
            if (MSB_FIRST) sr <= {sr[WIDTH-2:0], 1'b0};
            else           sr <= {1'b0, sr[WIDTH-1:1]};
        end
    end

    assign tap = MSB_FIRST ? sr[WIDTH-1] : sr[0];
endmodule

// File: rtl/piso_tx_ctrl.sv
// Frame sequencer: accepts a word, holds each bit DIV clocks, flags the stream, pulses done.
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DIV       = DEF_DIV,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    piso_tx_ctrl_if.slave  bus
);
    localparam int unsigned BW = bit_cnt_w(WIDTH);
    localparam int unsigned DW = div_cnt_w(DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t        state, state_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt;
    logic [DW-1:0] div_cnt, div_cnt_nxt;
    logic          pl, sh, clr, tap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            div_cnt <= div_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        pl          = 1'b0;
        sh          = 1'b0;
        clr         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    pl          = 1'b1;
                    bit_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = LOAD;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    clr         = 1'b1;
                    bit_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // abort wins even on the final cycle of the last bit
                if (bus.abort) begin
                    clr         = 1'b1;
                    bit_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = DONE;
                    end else begin
                        sh          = 1'b1;
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    piso_shift_datapath #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_datapath (
        .clk(clk),
        .rst(reset),
        .pl (pl),
        .sh (sh),
        .clr(clr),
        .din(bus.in_data),
        .tap(tap)
    );

    assign bus.in_ready = (state == IDLE) && !reset;
    assign bus.so       = (state == SHIFT) && tap;
    assign bus.so_valid = (state == SHIFT);
    assign bus.busy     = (state == LOAD) || (state == SHIFT);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: three configurations driven from one linear sequence.
module tb_piso_tx_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   done_cnt;

    piso_tx_ctrl_if #(.WIDTH(4)) ia ();
    piso_tx_ctrl_if #(.WIDTH(4)) ib ();
    piso_tx_ctrl_if #(.WIDTH(4)) ic ();

    piso_tx_ctrl #(.WIDTH(4), .DIV(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    piso_tx_ctrl #(.WIDTH(4), .DIV(2), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
    piso_tx_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ic.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%b required=%b", tag, obs, exp);
            $error("%s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    // Full frame on the WIDTH=4/DIV=2/MSB-first unit; entered and left at a negedge in IDLE.
    task automatic frame_a(input logic [3:0] d, input logic [7:0] exp_so);
        ia.in_data  = d;
        ia.in_valid = 1'b1;
        @(negedge clk);
        chk1("a_load_busy", ia.busy, 1'b1);
        chk1("a_load_so_valid", ia.so_valid, 1'b0);
        chk1("a_load_in_ready", ia.in_ready, 1'b0);
        ia.in_valid = 1'b0;
        ia.abort    = 1'b0;
        ia.in_data  = ~d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("a_shift_so_valid", ia.so_valid, 1'b1);
            chk1("a_shift_so", ia.so, exp_so[7-i]);
            chk1("a_shift_done", ia.done, 1'b0);
            chk1("a_shift_in_ready", ia.in_ready, 1'b0);
            ia.in_valid = (i == 3) || (i == 7);
        end
        @(negedge clk);
        chk1("a_done_pulse", ia.done, 1'b1);
        chk1("a_done_busy", ia.busy, 1'b0);
        chk1("a_done_so_valid", ia.so_valid, 1'b0);
        chk1("a_done_so", ia.so, 1'b0);
        chk1("a_done_in_ready", ia.in_ready, 1'b0);
        ia.in_valid = 1'b0;
        @(negedge clk);
        chk1("a_idle_done", ia.done, 1'b0);
        chk1("a_idle_in_ready", ia.in_ready, 1'b1);
        chk1("a_idle_busy", ia.busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  exp_b;
        logic [13:0] ec_valid, ec_so, ec_done;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        reset    = 1'b1;
        ia.in_data = '0; ia.in_valid = 1'b0; ia.abort = 1'b0;
        ib.in_data = '0; ib.in_valid = 1'b0; ib.abort = 1'b0;
        ic.in_data = '0; ic.in_valid = 1'b0; ic.abort = 1'b0;

        #2;
        chk1("rst_in_ready", ia.in_ready, 1'b0);
        chk1("rst_so", ia.so, 1'b0);
        chk1("rst_so_valid", ia.so_valid, 1'b0);
        chk1("rst_busy", ia.busy, 1'b0);
        chk1("rst_done", ia.done, 1'b0);
        chk1("rst_in_ready_c", ic.in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("post_rst_in_ready", ia.in_ready, 1'b1);
        chk1("post_rst_in_ready_b", ib.in_ready, 1'b1);
        @(negedge clk);

        // MSB first, DIV=2
        frame_a(4'b1010, 8'b11001100);

        // LSB first, DIV=2
        exp_b       = 8'b11110011;
        ib.in_data  = 4'b1011;
        ib.in_valid = 1'b1;
        @(negedge clk);
        chk1("b_load_busy", ib.busy, 1'b1);
        ib.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("b_so_valid", ib.so_valid, 1'b1);
            chk1("b_so", ib.so, exp_b[7-i]);
        end
        @(negedge clk);
        chk1("b_done", ib.done, 1'b1);
        @(negedge clk);
        chk1("b_idle_in_ready", ib.in_ready, 1'b1);
        chk1("b_idle_done", ib.done, 1'b0);

        // DIV=1 back-to-back: L S S S S D I L S S S S D I
        ec_valid    = 14'b01111000111100;
        ec_so       = 14'b00110000100100;
        ec_done     = 14'b00000100000010;
        ic.in_data  = 4'b0110;
        ic.in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk1("c_so_valid", ic.so_valid, ec_valid[13-i]);
            chk1("c_so", ic.so, ec_so[13-i]);
            chk1("c_done", ic.done, ec_done[13-i]);
            if (ic.done === 1'b1) done_cnt++;
            if (i == 6 || i == 13) chk1("c_idle_in_ready", ic.in_ready, 1'b1);
            if (i == 0) ic.in_data = 4'b1001;
            if (i == 7) ic.in_valid = 1'b0;
        end
        checks++;
        assert (done_cnt == 2) else begin
            failures++;
            $display("FAIL c_done_count observed=%0d required=2", done_cnt);
            $error("c_done_count observed=%0d required=2", done_cnt);
        end

        // abort on the 3rd SHIFT cycle
        ia.in_data  = 4'b1111;
        ia.in_valid = 1'b1;
        @(negedge clk);
        ia.in_valid = 1'b0;
        @(negedge clk);
        chk1("ab_s1_so", ia.so, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk1("ab_s3_so_valid", ia.so_valid, 1'b1);
        ia.abort = 1'b1;
        @(negedge clk);
        chk1("ab_so_valid", ia.so_valid, 1'b0);
        chk1("ab_so", ia.so, 1'b0);
        chk1("ab_busy", ia.busy, 1'b0);
        chk1("ab_done", ia.done, 1'b0);
        chk1("ab_in_ready", ia.in_ready, 1'b1);
        ia.abort = 1'b0;
        @(negedge clk);
        chk1("ab_after_done", ia.done, 1'b0);
        chk1("ab_after_in_ready", ia.in_ready, 1'b1);

        // abort together with in_valid in IDLE is ignored
        ia.abort = 1'b1;
        frame_a(4'b0001, 8'b00000011);

        // abort on the final cycle of the last bit suppresses done
        ia.in_data  = 4'b1111;
        ia.in_valid = 1'b1;
        @(negedge clk);
        ia.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("ablast_so_valid", ia.so_valid, 1'b1);
            ia.abort = (i == 7);
        end
        @(negedge clk);
        chk1("ablast_done", ia.done, 1'b0);
        chk1("ablast_in_ready", ia.in_ready, 1'b1);
        chk1("ablast_so_valid_off", ia.so_valid, 1'b0);
        ia.abort = 1'b0;
        @(negedge clk);
        chk1("ablast_after_done", ia.done, 1'b0);

        // asynchronous reset between clock edges mid-SHIFT
        ia.in_data  = 4'b1111;
        ia.in_valid = 1'b1;
        @(negedge clk);
        ia.in_valid = 1'b0;
        @(negedge clk);
        chk1("ar_pre_so", ia.so, 1'b1);
        chk1("ar_pre_busy", ia.busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("ar_so", ia.so, 1'b0);
        chk1("ar_so_valid", ia.so_valid, 1'b0);
        chk1("ar_busy", ia.busy, 1'b0);
        chk1("ar_in_ready", ia.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("ar_rel_in_ready", ia.in_ready, 1'b1);
        frame_a(4'b0110, 8'b00111100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
- Sequencer for a parallel-in/serial-out shift-register datapath.
- Accepts a WIDTH-bit word over a valid/ready handshake, parallel-loads it, and shifts it out one bit per DIV clocks.
- Flags the serial stream with so_valid and pulses done at the end of each frame.
- Sits between a word producer and a serial sink; it is the control layer over the existing PIPO/SISO/SIPO-style shift registers.

Parameters:
- WIDTH, 4, word length in bits; must be at least 2.
- DIV, 2, clocks per serial bit; must be at least 1.
- MSB_FIRST, 1, 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- in_data, input, WIDTH, parallel word to transmit.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block can accept a word.
- abort, input, 1, synchronous frame cancel.
- so, output, 1, serial data out.
- so_valid, output, 1, so carries a frame bit.
- busy, output, 1, frame in progress (LOAD or SHIFT state).
- done, output, 1, one-cycle pulse when a frame completes normally.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, shift register=0, bit_cnt=0, div_cnt=0
  - so=0, so_valid=0, busy=0, done=0
  - in_ready=0 while reset is high.
- All outputs are registered or decoded from registered state. in_ready = (state==IDLE) && !reset.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: pl pulse loads in_data into the datapath, bit_cnt=0, div_cnt=0, go to LOAD.
  - in_valid without a handshake leaves the state unchanged.
- LOAD (1 cycle):
  - busy=1, so_valid=0, in_ready=0. Always go to SHIFT.
- SHIFT:
  - busy=1, so_valid=1.
  - so = datapath tap: bit WIDTH-1 if MSB_FIRST, else bit 0.
  - div_cnt increments every cycle.
  - When div_cnt==DIV-1: div_cnt wraps to 0.
    - If bit_cnt==WIDTH-1, go to DONE.
    - Otherwise shift the datapath one position (zero fill) and increment bit_cnt.
  - Each bit is held exactly DIV cycles.
- DONE (1 cycle):
  - done=1, busy=0, so_valid=0, so=0, in_ready=0. Go to IDLE.
- Latency and throughput:
  - First serial bit appears 2 cycles after the accept edge (one LOAD cycle, then SHIFT).
  - done asserts WIDTH*DIV+1 cycles after the first bit.
  - Minimum word-to-word spacing is WIDTH*DIV+3 cycles; in_ready returns the cycle after DONE.
- Boundary rules:
  - abort in LOAD or SHIFT: next state IDLE, so=0, so_valid=0, no done pulse, counters cleared, shift register cleared.
  - abort in IDLE or DONE has no effect.
  - abort and in_valid together in IDLE: abort is ignored and the word is accepted.
  - abort on the last bit's final cycle overrides completion: IDLE, no done.
  - in_data may change freely after the accept edge; the datapath holds the captured copy.
  - DIV=1: a new bit every cycle and div_cnt is constant 0.
  - reset mid-frame: immediate return to reset values; the frame is lost silently.
- Width rules:
  - bit_cnt is clog2(WIDTH) bits wide.
  - div_cnt is max(1,clog2(DIV)) bits wide.
  - Neither counter ever exceeds its terminal value.

Decomposition:
- Package piso_pkg holds:
  - state enum {IDLE, LOAD, SHIFT, DONE}, 2-bit encoding
  - clog2-based width constants for bit_cnt and div_cnt.
- Sub-module piso_shift_datapath (WIDTH, MSB_FIRST) contains:
  - WIDTH-bit register with async reset
  - pl (load) and sh (shift) enables; pl has priority
  - clr input used on abort
  - serial tap output.
- piso_tx_ctrl holds only the FSM and both counters.

Test Plan:
- WIDTH=4, DIV=2, MSB_FIRST=1; after reset, send 4'b1010 -> so = 1,1,0,0,1,1,0,0 with so_valid high for exactly 8 cycles; done pulses 1 cycle, 9 cycles after the first bit; in_ready high the following cycle.
- Same config with MSB_FIRST=0, send 4'b1011 -> so = 1,1,1,1,0,0,1,1.
- DIV=1, in_valid held high with words 4'b0110 then 4'b1001 -> so = 0,1,1,0, then a 3-cycle gap (DONE, IDLE, LOAD), then 1,0,0,1; exactly two done pulses.
- abort asserted on the 3rd SHIFT cycle of 4'b1111 -> so_valid drops the next cycle, no done pulse, in_ready=1 the next cycle; a following 4'b0001 transmits correctly.
- reset asserted asynchronously mid-SHIFT (between clock edges) -> so, so_valid and busy go to 0 immediately without waiting for clk; after release, in_ready=1 and a new frame works.
- in_valid pulsed during SHIFT and DONE -> ignored (no accept, in_ready=0); in_data changed after accept -> serial stream still matches the originally captured word.
